// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-clock edge strobe, h/v counters, registered sync/video/coords.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN; otherwise frame_cnt_vs is tied to zero.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_vs,
  input  logic       rst_n_vs,
  input  logic       pix_clk_vs,
  output logic       hsync_vs,
  output logic       vsync_vs,
  output logic       video_on_vs,
  output logic [9:0] px_x_vs,
  output logic [9:0] px_y_vs,
  output logic       frame_start_vs,
  output logic [7:0] frame_cnt_vs
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       r_p0;
  logic       r_p1;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_frame_start;

  logic       w_strobe;
  logic       w_h_wrap;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_frame_wrap;

  assign w_strobe     = r_p0 & ~r_p1;
  assign w_h_wrap     = (r_h == H_LAST);
  assign w_h_next     = w_h_wrap ? 10'd0 : r_h + 10'd1;
  assign w_v_next     = w_h_wrap ? ((r_v == V_LAST) ? 10'd0 : r_v + 10'd1) : r_v;
  assign w_frame_wrap = w_strobe && (w_h_next == 10'd0) && (w_v_next == 10'd0);

  // Outputs are decoded from the next counter values so they line up with px_x/px_y.
  always_ff @(posedge clk_vs or negedge rst_n_vs) begin
    if (!rst_n_vs) begin
      r_p0          <= 1'b0;
      r_p1          <= 1'b0;
      r_h           <= H_LAST;
      r_v           <= V_LAST;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_p0          <= pix_clk_vs;
      r_p1          <= r_p0;
      r_frame_start <= w_frame_wrap;
      if (w_strobe) begin
        r_h        <= w_h_next;
        r_v        <= w_v_next;
        r_hsync    <= ~((w_h_next >= HS_START) && (w_h_next < HS_END));
        r_vsync    <= ~((w_v_next >= VS_START) && (w_v_next < VS_END));
        r_video_on <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk_vs or negedge rst_n_vs) begin
    if (!rst_n_vs) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt_vs = r_frame_cnt;
`else
  assign frame_cnt_vs = 8'd0;
`endif

  assign hsync_vs       = r_hsync;
  assign vsync_vs       = r_vsync;
  assign video_on_vs    = r_video_on;
  assign px_x_vs        = r_h;
  assign px_y_vs        = r_v;
  assign frame_start_vs = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunken-timing instance for fast frame wraps plus a default 640x480 instance,
// both checked every cycle against a linear pixel-index reference model.
module tb_vga_sync_gen;

  localparam int SHV = 4, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVV = 3, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix = 1'b0;

  logic       s_hs, s_vs, s_von, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;
  logic       d_hs, d_vs, d_von, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_small (
    .clk_vs(clk), .rst_n_vs(rst_n), .pix_clk_vs(pix),
    .hsync_vs(s_hs), .vsync_vs(s_vs), .video_on_vs(s_von),
    .px_x_vs(s_x), .px_y_vs(s_y), .frame_start_vs(s_fs), .frame_cnt_vs(s_fc)
  );

  vga_sync_gen u_full (
    .clk_vs(clk), .rst_n_vs(rst_n), .pix_clk_vs(pix),
    .hsync_vs(d_hs), .vsync_vs(d_vs), .video_on_vs(d_von),
    .px_x_vs(d_x), .px_y_vs(d_y), .frame_start_vs(d_fs), .frame_cnt_vs(d_fc)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  // Reference model: number of pixel strobes since reset, plus the last two sampled pix_clk values.
  int   cnt = 0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_strobe = 1'b0;
  int   fs_small = 0;
  int   fs_full = 0;
  int   div_phase = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string pfx, input int hv, input int hf, input int hs, input int hb,
                           input int vv, input int vf, input int vs, input int vb,
                           input logic [9:0] x, input logic [9:0] y, input logic hsy, input logic vsy,
                           input logic von, input logic fs, input logic [7:0] fc, inout int fs_total);
    int ht, vt, tot, idx, ex, ey, efc;
    logic e_hs, e_vs, e_von, e_fs;
    ht    = hv + hf + hs + hb;
    vt    = vv + vf + vs + vb;
    tot   = ht * vt;
    idx   = (cnt + tot - 1) % tot;
    ex    = idx % ht;
    ey    = idx / ht;
    e_hs  = !((ex >= hv + hf) && (ex < hv + hf + hs));
    e_vs  = !((ey >= vv + vf) && (ey < vv + vf + vs));
    e_von = (ex < hv) && (ey < vv);
    e_fs  = m_strobe && (ex == 0) && (ey == 0);
    if (e_fs) fs_total++;
`ifdef VGA_FRAME_CNT_EN
    efc = fs_total % 256;
`else
    efc = 0;
`endif
    check_val({pfx, ".px_x"}, 32'(x), 32'(ex));
    check_val({pfx, ".px_y"}, 32'(y), 32'(ey));
    check_val({pfx, ".hsync"}, 32'(hsy), 32'(e_hs));
    check_val({pfx, ".vsync"}, 32'(vsy), 32'(e_vs));
    check_val({pfx, ".video_on"}, 32'(von), 32'(e_von));
    check_val({pfx, ".frame_start"}, 32'(fs), 32'(e_fs));
    check_val({pfx, ".frame_cnt"}, 32'(fc), 32'(efc));
  endtask

  task automatic check_all();
    check_dut("small", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
              s_x, s_y, s_hs, s_vs, s_von, s_fs, s_fc, fs_small);
    check_dut("full", 640, 16, 96, 48, 480, 10, 2, 33,
              d_x, d_y, d_hs, d_vs, d_von, d_fs, d_fc, fs_full);
  endtask

  task automatic model_reset();
    cnt      = 0;
    m_s1     = 1'b0;
    m_s2     = 1'b0;
    m_strobe = 1'b0;
  endtask

  // One clk with pix_clk held at pin across the rising edge; the model advances then both DUTs are checked.
  task automatic run_cycle(input logic pin);
    pix = pin;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_strobe = m_s1 && !m_s2;
      if (m_strobe) cnt++;
      m_s2 = m_s1;
      m_s1 = pix;
    end
    check_all();
  endtask

  task automatic run_div(input int n);
    for (int i = 0; i < n; i++) begin
      run_cycle(div_phase < 2);
      div_phase = (div_phase + 1) % 4;
    end
  endtask

  // Reset pulse landing between clock edges; outputs must drop to the reset state before any edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run_cycle(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) run_cycle(1'b0);
    check_val("reset.full_x", 32'(d_x), 32'd799);
    check_val("reset.full_y", 32'(d_y), 32'd524);
    rst_n = 1'b1;

    for (int i = 0; i < 5000 && cnt != 301; i++) run_div(1);
    check_val("reach_x300", 32'(cnt), 32'd301);
    check_val("hold.full_x_before", 32'(d_x), 32'd300);
    repeat (100) run_cycle(1'b0);
    check_val("hold.full_x_after", 32'(d_x), 32'd300);
    div_phase = 0;
    run_div(12);

    run_div(257 * SHT * SVT * 4 + 64);

    repeat (400) begin
      case ($urandom_range(0, 4))
        0: run_div($urandom_range(1, 60));
        1: repeat ($urandom_range(1, 30)) run_cycle(1'b0);
        2: repeat ($urandom_range(1, 30)) run_cycle(1'b1);
        3: begin
          run_cycle(1'b1);
          repeat ($urandom_range(1, 4)) run_cycle(1'b0);
        end
        default: async_reset();
      endcase
    end
    run_div(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
